// File: rtl/mine_pkg.sv
// mine_pkg: shared types and constants for the SHA-256 mining sequencer.
//   state_e  - sequencer FSM states
//   ROUNDS   - compression rounds per nonce, CYCLE_W - round index width
//   nonce_t / hash_t - nonce and hash/target words
package mine_pkg;

    localparam int ROUNDS  = 64;
    localparam int CYCLE_W = 6;
    localparam int NONCE_W = 32;
    localparam int HASH_W  = 256;

    typedef logic [NONCE_W-1:0] nonce_t;
    typedef logic [HASH_W-1:0]  hash_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/mine_sequencer_if.sv
// mine_sequencer_if: host + datapath bundle of the mining sequencer.
//   master - host/datapath side: drives start, abort, range, target, hash
//   slave  - sequencer side: drives sha_init, solve_en, cycle, nonce and status
interface mine_sequencer_if
    import mine_pkg::*;
#(
    parameter int NONCE_W_P = NONCE_W,
    parameter int HASH_W_P  = HASH_W,
    parameter int CYCLE_W_P = CYCLE_W
);
    // host control / datapath result
    logic                 start;
    logic                 abort;
    logic [NONCE_W_P-1:0] nonce_start;
    logic [NONCE_W_P-1:0] nonce_end;
    logic [HASH_W_P-1:0]  target;
    logic                 hash_valid;
    logic [HASH_W_P-1:0]  hash;

    // datapath control / host status
    logic                 sha_init;
    logic                 solve_en;
    logic [CYCLE_W_P-1:0] cycle;
    logic [NONCE_W_P-1:0] nonce;
    logic                 busy;
    logic                 found;
    logic                 exhausted;
    logic [NONCE_W_P-1:0] found_nonce;
    logic [NONCE_W_P-1:0] attempts;

    modport master (
        output start, abort, nonce_start, nonce_end, target, hash_valid, hash,
        input  sha_init, solve_en, cycle, nonce, busy, found, exhausted,
               found_nonce, attempts
    );

    modport slave (
        input  start, abort, nonce_start, nonce_end, target, hash_valid, hash,
        output sha_init, solve_en, cycle, nonce, busy, found, exhausted,
               found_nonce, attempts
    );

endinterface

// File: rtl/mine_sequencer_round_counter.sv
// round_counter: round index counter for the compression datapath.
//   clk, rst  - clock, async active-high reset
//   clr_i     - synchronous clear (wins over enable)
//   en_i      - advance by one
//   cnt_o     - current round index
//   last_o    - high when cnt_o == ROUNDS-1
module round_counter #(
    parameter int ROUNDS = 64,
    parameter int W      = $clog2(ROUNDS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == W'(ROUNDS - 1));

endmodule

// File: rtl/mine_sequencer.sv
// mine_sequencer: sweeps a nonce range through the SHA-256 datapath.
// For each nonce: pulse sha_init, run ROUNDS rounds with solve_en, wait for
// hash_valid, compare hash <= target. Reports found/exhausted to the host.
//   clk, rst - clock, async active-high reset
//   bus      - mine_sequencer_if.slave (host control/status + datapath handshake)
module mine_sequencer
    import mine_pkg::*;
#(
    parameter int ROUNDS_P = ROUNDS,
    parameter int NONCE_W  = mine_pkg::NONCE_W,
    parameter int HASH_W   = mine_pkg::HASH_W
) (
    input  logic              clk,
    input  logic              rst,
    mine_sequencer_if.slave   bus
);

    localparam int CW = $clog2(ROUNDS_P);

    state_e              state_q, state_d;
    logic [NONCE_W-1:0]  nonce_q, end_q, fnonce_q, att_q;
    logic [HASH_W-1:0]   target_q, hash_q;
    logic                found_q, exh_q;
    logic                sha_init_q, solve_en_q, busy_q;

    logic                last_rnd;
    logic [CW-1:0]       cycle_w;
    logic                hit;
    logic                idle_like;
    logic                start_acc;

    assign hit       = (hash_q <= target_q);
    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign start_acc = idle_like && bus.start && !bus.abort;

    // Counter only advances in ROUND; any abort or leaving ROUND parks it at 0
    // so INIT always presents cycle=0.
    round_counter #(.ROUNDS(ROUNDS_P), .W(CW)) u_rnd (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (bus.abort || (state_q != ROUND) || last_rnd),
        .en_i   (state_q == ROUND),
        .cnt_o  (cycle_w),
        .last_o (last_rnd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = INIT;
            INIT:       state_d = ROUND;
            ROUND:      if (last_rnd) state_d = WAIT;
            WAIT:       if (bus.hash_valid) state_d = CHECK;
            CHECK:      state_d = (hit || (nonce_q == end_q)) ? DONE : INIT;
            default:    state_d = IDLE;
        endcase
        // abort overrides everything, including a simultaneous start
        if (bus.abort) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            nonce_q    <= '0;
            end_q      <= '0;
            target_q   <= '0;
            hash_q     <= '0;
            found_q    <= 1'b0;
            exh_q      <= 1'b0;
            fnonce_q   <= '0;
            att_q      <= '0;
            sha_init_q <= 1'b0;
            solve_en_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            // outputs are decoded from the next state so they line up with it
            sha_init_q <= (state_d == INIT);
            solve_en_q <= (state_d == ROUND);
            busy_q     <= (state_d == INIT) || (state_d == ROUND) ||
                          (state_d == WAIT) || (state_d == CHECK);

            if (start_acc) begin
                nonce_q  <= bus.nonce_start;
                end_q    <= bus.nonce_end;
                target_q <= bus.target;
                found_q  <= 1'b0;
                exh_q    <= 1'b0;
                att_q    <= '0;
            end

            if ((state_q == WAIT) && bus.hash_valid && !bus.abort) begin
                hash_q <= bus.hash;
            end

            // aborted CHECK leaves attempts and nonce untouched
            if ((state_q == CHECK) && !bus.abort) begin
                att_q <= att_q + 1'b1;
                if (hit) begin
                    found_q  <= 1'b1;
                    fnonce_q <= nonce_q;
                end else if (nonce_q == end_q) begin
                    exh_q <= 1'b1;
                end else begin
                    nonce_q <= nonce_q + 1'b1;
                end
            end
        end
    end

    assign bus.sha_init    = sha_init_q;
    assign bus.solve_en    = solve_en_q;
    assign bus.cycle       = cycle_w;
    assign bus.nonce       = nonce_q;
    assign bus.busy        = busy_q;
    assign bus.found       = found_q;
    assign bus.exhausted   = exh_q;
    assign bus.found_nonce = fnonce_q;
    assign bus.attempts    = att_q;

endmodule

// File: tb/tb_mine_sequencer.sv
// tb_mine_sequencer: directed table-driven bench for mine_sequencer.
// A small datapath responder answers each round burst with hash_valid after a
// programmable number of WAIT cycles; the hash it returns depends on the nonce.
module tb_mine_sequencer;
    import mine_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mine_sequencer_if bus ();

    mine_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        nonce_t ns;
        nonce_t ne;
        hash_t  target;
        nonce_t hit_nonce;
        hash_t  hash_hit;
        hash_t  hash_miss;
        int     wait_cyc;
        logic   e_found;
        logic   e_exh;
        nonce_t e_fn;
        nonce_t e_att;
        nonce_t e_nonce;
        int     e_inits;
        int     e_busy;
    } vec_t;

    int pass_cnt = 0;
    int total    = 0;

    // responder configuration
    nonce_t cur_hit_nonce;
    hash_t  cur_hash_hit, cur_hash_miss;
    int     cur_wait = 1;

    // monitor state
    int     busy_cnt = 0;
    int     init_cnt = 0;
    nonce_t visited[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // datapath responder: reacts to solve_en falling
    initial begin
        logic prev_se;
        logic pend;
        int   dly;
        prev_se = 1'b0;
        pend    = 1'b0;
        dly     = 0;
        bus.hash_valid = 1'b0;
        bus.hash       = '0;
        forever begin
            @(negedge clk);
            bus.hash_valid = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (prev_se && !bus.solve_en) begin
                    pend = 1'b1;
                    dly  = cur_wait - 1;
                end
                if (pend) begin
                    if (dly == 0) begin
                        bus.hash_valid = 1'b1;
                        bus.hash = (bus.nonce == cur_hit_nonce) ? cur_hash_hit : cur_hash_miss;
                        pend = 1'b0;
                    end else begin
                        dly--;
                    end
                end
            end
            prev_se = bus.solve_en;
        end
    end

    // monitor: counts busy cycles and sha_init pulses, logs visited nonces
    initial begin
        forever begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.sha_init) begin
                init_cnt++;
                visited.push_back(bus.nonce);
            end
        end
    end

    task automatic launch(input nonce_t ns, input nonce_t ne, input hash_t tgt,
                          input nonce_t hn, input hash_t hh, input hash_t hm, input int wc);
        @(negedge clk);
        cur_hit_nonce   = hn;
        cur_hash_hit    = hh;
        cur_hash_miss   = hm;
        cur_wait        = wc;
        bus.nonce_start = ns;
        bus.nonce_end   = ne;
        bus.target      = tgt;
        busy_cnt        = 0;
        init_cnt        = 0;
        visited.delete();
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int t;
        string tag;
        tag = $sformatf("v%0d", idx);
        launch(v.ns, v.ne, v.target, v.hit_nonce, v.hash_hit, v.hash_miss, v.wait_cyc);
        t = 0;
        while (bus.busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_timeout"}, 256'(t < 2000), 256'(1));
        check({tag, "_found"},     256'(bus.found),     256'(v.e_found));
        check({tag, "_exhausted"}, 256'(bus.exhausted), 256'(v.e_exh));
        if (v.e_found) check({tag, "_found_nonce"}, 256'(bus.found_nonce), 256'(v.e_fn));
        check({tag, "_attempts"},  256'(bus.attempts),  256'(v.e_att));
        check({tag, "_nonce"},     256'(bus.nonce),     256'(v.e_nonce));
        check({tag, "_inits"},     256'(init_cnt),      256'(v.e_inits));
        check({tag, "_busy_clks"}, 256'(busy_cnt),      256'(v.e_busy));
        for (int i = 0; i < visited.size(); i++)
            check($sformatf("%s_visit%0d", tag, i), 256'(visited[i]), 256'(nonce_t'(v.ns + nonce_t'(i))));
    endtask

    initial begin
        vec_t  vecs[6];
        hash_t T, ONES;
        int    t;
        logic  reached;

        T    = hash_t'(1) << 200;
        ONES = '1;
        //         ns            ne            target  hit  hash_hit          hash_miss      w  fnd exh fn  att nonce inits busy
        vecs[0] = '{32'd5,       32'd10,       ONES,   5,   hash_t'(256'h123), hash_t'(256'h123), 1, 1, 0, 5, 1, 5, 1, 67};
        vecs[1] = '{32'd0,       32'd2,        '0,     0,   hash_t'(1),      hash_t'(1),    1, 0, 1, 0, 3, 2, 3, 201};
        vecs[2] = '{32'hFFFFFFFE, 32'h1,       T,      1,   hash_t'(256'h10), ONES,         1, 1, 0, 1, 4, 1, 4, 268};
        vecs[3] = '{32'd7,       32'd7,        T,      7,   T,               T,             1, 1, 0, 7, 1, 7, 1, 67};
        vecs[4] = '{32'd7,       32'd7,        T,      7,   T + 1,           T + 1,         1, 0, 1, 0, 1, 7, 1, 67};
        vecs[5] = '{32'd3,       32'd4,        '0,     0,   hash_t'(5),      hash_t'(5),    5, 0, 1, 0, 2, 4, 2, 142};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.nonce_start = '0;
        bus.nonce_end   = '0;
        bus.target      = '0;
        #1;
        check("rst_busy",     256'(bus.busy),      256'(0));
        check("rst_solve_en", 256'(bus.solve_en),  256'(0));
        check("rst_sha_init", 256'(bus.sha_init),  256'(0));
        check("rst_found",    256'(bus.found),     256'(0));
        check("rst_attempts", 256'(bus.attempts),  256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // start together with abort in DONE: abort wins, no sweep
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("startabort_busy",     256'(bus.busy),     256'(0));
        check("startabort_sha_init", 256'(bus.sha_init), 256'(0));
        @(negedge clk);
        check("startabort_busy2",    256'(bus.busy),     256'(0));

        // abort at cycle 30 of the second nonce
        launch(32'd0, 32'd9, '0, 32'd100, hash_t'(1), hash_t'(1), 1);
        reached = 1'b0;
        t = 0;
        while (!reached && t < 500) begin
            if (init_cnt == 2 && bus.solve_en && bus.cycle == 6'd30) reached = 1'b1;
            else begin
                @(negedge clk);
                t++;
            end
        end
        check("abort_window", 256'(reached), 256'(1));
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy",      256'(bus.busy),      256'(0));
        check("abort_solve_en",  256'(bus.solve_en),  256'(0));
        check("abort_sha_init",  256'(bus.sha_init),  256'(0));
        check("abort_found",     256'(bus.found),     256'(0));
        check("abort_exhausted", 256'(bus.exhausted), 256'(0));
        check("abort_attempts",  256'(bus.attempts),  256'(1));
        check("abort_nonce",     256'(bus.nonce),     256'(1));
        check("abort_cycle",     256'(bus.cycle),     256'(0));
        // the responder's late hash_valid lands in IDLE and must be ignored
        repeat (5) @(negedge clk);
        check("abort_idle_busy",  256'(bus.busy),      256'(0));
        check("abort_idle_exh",   256'(bus.exhausted), 256'(0));
        check("abort_idle_found", 256'(bus.found),     256'(0));
        run_vec(10, vecs[0]);

        // async reset mid-ROUND
        launch(32'd100, 32'd200, '0, 32'd0, hash_t'(1), hash_t'(1), 1);
        reached = 1'b0;
        t = 0;
        while (!reached && t < 200) begin
            if (bus.solve_en && bus.cycle == 6'd20) reached = 1'b1;
            else begin
                @(negedge clk);
                t++;
            end
        end
        check("rstmid_window", 256'(reached), 256'(1));
        #2 rst = 1'b1;
        #1;
        check("rstmid_busy",        256'(bus.busy),        256'(0));
        check("rstmid_solve_en",    256'(bus.solve_en),    256'(0));
        check("rstmid_cycle",       256'(bus.cycle),       256'(0));
        check("rstmid_nonce",       256'(bus.nonce),       256'(0));
        check("rstmid_found_nonce", 256'(bus.found_nonce), 256'(0));
        check("rstmid_found",       256'(bus.found),       256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_after_busy",  256'(bus.busy),        256'(0));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mine_sequencer.md
Name: mine_sequencer

Overview:
Top-level controller for the SHA-256 mining datapath. Sweeps a programmed nonce range one nonce at a time. For each nonce it:
- pulses the datapath load;
- drives the 64-round enable and round index;
- waits for the final hash;
- compares the hash against the target.
Reports the winning nonce, or range exhaustion, to the host interface. It replaces the free-running cycle/nonce counter pair with one sequenced, abortable FSM.

Parameters:
ROUNDS, 64, compression rounds per nonce
NONCE_W, 32, nonce width
HASH_W, 256, hash/target width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin sweep (ignored while busy)
abort  in  1  level; terminate sweep
nonce_start  in  NONCE_W  first nonce, sampled on accepted start
nonce_end  in  NONCE_W  last nonce inclusive, sampled on accepted start
target  in  HASH_W  difficulty target, sampled on accepted start
hash_valid  in  1  datapath final hash available
hash  in  HASH_W  datapath final hash, big-endian numeric
sha_init  out  1  one-cycle pulse; datapath loads header and nonce
solve_en  out  1  round enable to datapath
cycle  out  6  current round index 0..ROUNDS-1
nonce  out  NONCE_W  nonce currently being hashed
busy  out  1  sweep in progress
found  out  1  sticky; hash <= target hit
exhausted  out  1  sticky; range finished, no hit
found_nonce  out  NONCE_W  winning nonce, valid when found=1
attempts  out  NONCE_W  nonces fully checked this sweep, wraps

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, including captured target and end registers.
- FSM states: IDLE, INIT, ROUND, WAIT, CHECK, DONE.
- IDLE: on start=1:
  - latch nonce_start into nonce; latch nonce_end and target;
  - clear found, exhausted and attempts;
  - go to INIT.
- INIT (1 cycle): sha_init=1, solve_en=0, cycle=0; go to ROUND.
- ROUND: solve_en=1, cycle increments every clk from 0. When cycle==ROUNDS-1, go to WAIT and reset cycle to 0.
- WAIT: solve_en=0. When hash_valid=1, register hash into an internal capture and go to CHECK. No timeout; abort is the only other exit.
- CHECK (1 cycle):
  - increment attempts;
  - hit = (captured hash <= target), unsigned HASH_W compare;
  - hit: found=1, found_nonce=nonce, go to DONE;
  - else if nonce==nonce_end: exhausted=1, go to DONE;
  - else nonce <= nonce+1 (mod 2^NONCE_W), go to INIT.
- DONE: busy=0, and found/exhausted/found_nonce hold. start behaves exactly as in IDLE.
- busy=1 in INIT, ROUND, WAIT, CHECK.
- Minimum latency per nonce is 67 clocks (INIT 1 + ROUND 64 + WAIT 1 + CHECK 1), reached when hash_valid is high on the first WAIT cycle.
- Wrap-around: nonce_end < nonce_start is legal. The sweep passes through 0xFFFFFFFF and then 0. nonce_start==nonce_end checks exactly one nonce.
- abort=1 in any busy state:
  - next state IDLE; solve_en and sha_init are 0 from the next cycle;
  - found and exhausted stay 0; nonce and attempts retain their last values.
  - abort has priority over hash_valid, the CHECK result and start.
- start while busy is ignored. start and abort asserted together in IDLE/DONE: abort wins, stay/return to IDLE, no sweep begins.
- hash_valid outside WAIT is ignored.
- Mid-operation rst: immediate return to the reset values. The datapath sees solve_en=0 asynchronously.

Decomposition:
- Package mine_pkg holds:
  - the state enum (IDLE, INIT, ROUND, WAIT, CHECK, DONE);
  - constants ROUNDS=64 and CYCLE_W=6;
  - typedefs nonce_t (32b) and hash_t (256b).
- One sub-module, round_counter: 6-bit counter with clear and enable, plus a last-round flag (cycle==ROUNDS-1). It is instantiated for the cycle output.
- The hash compare stays inline.

Test Plan:
- Single hit: nonce_start=5, nonce_end=10, target=all-ones, hash_valid one cycle after last round -> found=1, found_nonce=5, attempts=1, busy high for 67 clocks.
- Exhaust: range 0..2, target=0, hash=1 always -> exhausted=1, found=0, attempts=3, nonce=2, exactly 3 sha_init pulses.
- Wrap: range 0xFFFFFFFE..0x00000001, hit only when nonce==0x00000001 -> nonces 0xFFFFFFFE, 0xFFFFFFFF, 0, 1 visited in order; found_nonce=1; attempts=4.
- Boundary compare: hash==target -> hit; hash==target+1 -> no hit.
- Abort: assert abort at cycle=30 of the second nonce -> IDLE next clock, solve_en=0, found=exhausted=0, attempts=1; a later start runs a fresh sweep normally.
- Reset mid-ROUND and delayed hash_valid: 5-cycle WAIT stall -> CHECK only after hash_valid, 71 clocks per nonce. rst asserted mid-ROUND -> all outputs 0 without a clock edge.
